logic_unit_pipe: RTL and testbench

//  Parametrised, registered successor to the 4-bit bitwise gate bank.
//  One opcode-selected bitwise op per transaction on WIDTH-bit operands, with valid/ready handshakes.

---
 rtl/logic_unit_pipe.sv | 109 ++++++++++
 tb/tb_logic_unit_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered WIDTH-bit bitwise op unit with valid/ready
// handshakes, a chain accumulator feeding operand A, and zero/parity flags.
// Ports: clk, rst_n (async, active low); in_valid/in_ready, a, b, op, chain,
//   acc_clr on the input side; out_valid/out_ready, y, zero, parity on the
//   output side. Define LOGIC_UNIT_POPCNT_EN to add the popcnt output.
module logic_unit_pipe #(
   parameter int unsigned      WIDTH    = 4,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             chain,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
`ifdef LOGIC_UNIT_POPCNT_EN
   output logic             parity,
   output logic [$clog2(WIDTH+1)-1:0] popcnt
`else
   output logic             parity
`endif
);

   logic             accept;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] res;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear on a chained beat applies before the operand is used.
   always_comb begin
      op_a = a;
      if (chain) begin
         op_a = acc_clr ? ACC_INIT : acc;
      end
   end

   always_comb begin
      res = '0;
      unique case (op)
         3'b000: res = op_a & b;
         3'b001: res = op_a | b;
         3'b010: res = op_a ^ b;
         3'b011: res = ~(op_a & b);
         3'b100: res = ~(op_a | b);
         3'b101: res = ~(op_a ^ b);
         3'b110: res = op_a & ~b;
         3'b111: res = b;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
         zero      <= 1'b0;
         parity    <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         y         <= res;
         zero      <= (res == '0);
         parity    <= ^res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // The new result takes priority over a clear in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= ACC_INIT;
      end else if (accept) begin
         acc <= res;
      end else if (acc_clr) begin
         acc <= ACC_INIT;
      end
   end

`ifdef LOGIC_UNIT_POPCNT_EN
   localparam int PW = $clog2(WIDTH + 1);

   logic [PW-1:0] pc_next;

   always_comb begin
      pc_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pc_next = pc_next + PW'(res[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         popcnt <= '0;
      end else if (accept) begin
         popcnt <= pc_next;
      end
   end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized checks of logic_unit_pipe
// against a truth-table reference model and an in-order result scoreboard.
module tb_logic_unit_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic [2:0] op = '0;
   logic       chain = 1'b0;
   logic       acc_clr = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [3:0] y;
   logic       zero;
   logic       parity;
`ifdef LOGIC_UNIT_POPCNT_EN
   logic [2:0] popcnt;
`endif

   int errors = 0;
   int checks = 0;

   logic_unit_pipe #(.WIDTH(4), .ACC_INIT(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op),
      .chain(chain), .acc_clr(acc_clr),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero),
`ifdef LOGIC_UNIT_POPCNT_EN
      .parity(parity), .popcnt(popcnt)
`else
      .parity(parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
      end
   endtask

   // Truth table per op, indexed by {a_bit, b_bit}.
   logic [3:0] tt [8];
   initial begin
      tt[0] = 4'b1000; tt[1] = 4'b1110;
      tt[2] = 4'b0110; tt[3] = 4'b0111;
      tt[4] = 4'b0001; tt[5] = 4'b1001;
      tt[6] = 4'b0100; tt[7] = 4'b1010;
   end

   function automatic logic [3:0] lut(input logic [2:0] o,
                                      input logic [3:0] x,
                                      input logic [3:0] z);
      logic [3:0] r;
      logic [3:0] row;
      row = tt[o];
      for (int i = 0; i < 4; i++) r[i] = row[{x[i], z[i]}];
      return r;
   endfunction

   // Reference model state
   logic       m_valid = 1'b0;
   logic [3:0] m_y = '0;
   logic       m_zero = 1'b0;
   logic       m_par = 1'b0;
   logic [3:0] m_acc = '0;
   int         n_acc = 0;
   logic [3:0] q[$];

   always @(posedge clk or negedge rst_n) begin
      logic       take;
      logic [3:0] opa;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_y     = '0;
         m_zero  = 1'b0;
         m_par   = 1'b0;
         m_acc   = '0;
         q.delete();
      end else begin
         take = in_valid && (!m_valid || out_ready);
         if (take) begin
            if (!chain) opa = a;
            else if (acc_clr) opa = 4'b0000;
            else opa = m_acc;
            m_y     = lut(op, opa, b);
            m_zero  = (m_y == 4'b0000);
            m_par   = ($countones(m_y) % 2) == 1;
            m_valid = 1'b1;
            m_acc   = m_y;
            q.push_back(m_y);
            n_acc++;
         end else begin
            if (m_valid && out_ready) m_valid = 1'b0;
            if (acc_clr) m_acc = 4'b0000;
         end
      end
   end

   // Per-cycle compare, away from the active edge.
   always @(negedge clk) begin
      logic [3:0] e;
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("y", y, m_y);
      chk("zero", zero, m_zero);
      chk("parity", parity, m_par);
`ifdef LOGIC_UNIT_POPCNT_EN
      chk("popcnt", popcnt, (m_valid || m_zero || m_y != 0) ?
          $countones(m_y) : 0);
`endif
      if (rst_n && out_valid === 1'b1 && out_ready) begin
         if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
         end else begin
            e = q.pop_front();
            chk("sb_order", y, e);
         end
      end
   end

   task automatic drive(input logic v, input logic [3:0] xa,
                        input logic [3:0] xb, input logic [2:0] xo,
                        input logic ch, input logic clr,
                        input logic rdy);
      in_valid = v; a = xa; b = xb; op = xo;
      chain = ch; acc_clr = clr; out_ready = rdy;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] e1 [8];
   logic       p1 [8];

   initial begin
      int start;
      int cyc;
      e1[0] = 4'b1000; e1[1] = 4'b1110; e1[2] = 4'b0110; e1[3] = 4'b0111;
      e1[4] = 4'b0001; e1[5] = 4'b1001; e1[6] = 4'b0100; e1[7] = 4'b1010;
      p1[0] = 1; p1[1] = 1; p1[2] = 0; p1[3] = 1;
      p1[4] = 1; p1[5] = 0; p1[6] = 1; p1[7] = 0;

      rst_n = 1'b0;
      tick; tick;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_zero", zero, 0);
      chk("rst_parity", parity, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      // 1: all ops, one per cycle
      for (int i = 0; i < 8; i++) begin
         drive(1, 4'b1100, 4'b1010, 3'(i), 0, 0, 1);
         tick;
         chk("t1_y", y, e1[i]);
         chk("t1_zero", zero, 0);
         chk("t1_parity", parity, p1[i]);
      end

      // 2: chain, then chain with clear
      drive(1, 4'b0101, 4'b0011, 3'd2, 0, 0, 1);
      tick;
      chk("t2_y0", y, 4'b0110);
      drive(1, 4'b0000, 4'b1111, 3'd2, 1, 0, 1);
      tick;
      chk("t2_chain", y, 4'b1001);
      drive(1, 4'b0101, 4'b0011, 3'd2, 0, 0, 1);
      tick;
      drive(1, 4'b0000, 4'b1111, 3'd2, 1, 1, 1);
      tick;
      chk("t2_chain_clr", y, 4'b1111);

      // 3: stall
      drive(1, 4'b1100, 4'b1010, 3'd0, 0, 0, 1);
      tick;
      chk("t3_y", y, 4'b1000);
      drive(1, 4'b0011, 4'b0100, 3'd1, 0, 0, 0);
      #1;
      chk("t3_in_ready", in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("t3_hold_y", y, 4'b1000);
         chk("t3_hold_v", out_valid, 1);
      end
      out_ready = 1'b1;
      tick;
      chk("t3_new_y", y, 4'b0111);
      drive(0, 4'b0000, 4'b0000, 3'd0, 0, 0, 1);
      tick;
      chk("t3_drained", out_valid, 0);

      // 4: zero flag and popcount
      drive(1, 4'b1111, 4'b0000, 3'd0, 0, 0, 1);
      tick;
      chk("t4_y", y, 4'b0000);
      chk("t4_zero", zero, 1);
      chk("t4_parity", parity, 0);
`ifdef LOGIC_UNIT_POPCNT_EN
      drive(1, 4'b1111, 4'b0000, 3'd1, 0, 0, 1);
      tick;
      chk("t4_popcnt", popcnt, 4);
`endif

      // 5: async reset mid-stall, chained op after reset
      drive(1, 4'b1100, 4'b1010, 3'd0, 0, 0, 1);
      tick;
      drive(0, 4'b0000, 4'b0000, 3'd0, 0, 0, 0);
      tick;
      chk("t5_stalled", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_y", y, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 4'b1111, 4'b0101, 3'd2, 1, 0, 1);
      tick;
      chk("t5_chain_acc0", y, 4'b0101);

      // 6: randomized stream
      start = n_acc;
      cyc = 0;
      while (n_acc - start < 16 && cyc < 300) begin
         drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
               3'($urandom), $urandom_range(0, 1) == 1,
               $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
         tick;
         cyc++;
      end
      chk("t6_budget", n_acc - start >= 16, 1);
      drive(0, 4'b0000, 4'b0000, 3'd0, 0, 0, 1);
      tick; tick;
      chk("t6_sb_left", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
